// File: rtl/tans_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : tans_bit_packer
// Purpose  : Packs 0..3-bit recoder symbols LSB-first into OUT_W-bit words,
//            appends the final tANS state at flush and zero-pads the tail.
// Revision : 1.0
// ============================================================================
module tans_bit_packer #(
    parameter int OUT_W   = 8,
    parameter int ACC_W   = 16,
    parameter int STATE_W = 4,
    parameter int BITS_W  = 12
) (
    input  logic               PHI,
    input  logic               RST_N,
    input  logic               I_F,
    input  logic               I_V,
    input  logic [1:0]         BTR,
    input  logic [2:0]         o_stream,
    input  logic               FLUSH,
    input  logic [STATE_W-1:0] final_state,
    input  logic               O_RDY,
    output logic               O_VLD,
    output logic [OUT_W-1:0]   O_WORD,
    output logic               O_LAST,
    output logic [BITS_W-1:0]  O_BITS,
    output logic               O_DONE,
    output logic               O_OVF
);

    localparam int ADD_W  = 3 + STATE_W;
    localparam int WIDE_W = ACC_W + ADD_W;
    localparam int CNT_W  = $clog2(ACC_W + 1);
    localparam int NADD_W = $clog2(ADD_W + 1);
    localparam int SUM_W  = $clog2(WIDE_W + 1);

    localparam logic [CNT_W-1:0] c_OUT_W_CNT = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] c_ACC_W_CNT = CNT_W'(ACC_W);
    localparam logic [SUM_W-1:0] c_ACC_W_SUM = SUM_W'(ACC_W);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q,   acc_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [BITS_W-1:0]   bits_q,  bits_d;
    logic                ovf_q,   ovf_d;

    logic                w_vld;
    logic                w_last;
    logic                w_xfer;
    logic                w_take_in;
    logic                w_take_fs;
    logic [ACC_W-1:0]    w_base;
    logic [CNT_W-1:0]    w_bcnt;
    logic [2:0]          w_in_mask;
    logic [1:0]          w_nin;
    logic [ADD_W-1:0]    w_data;
    logic [NADD_W-1:0]   w_nadd;
    logic [WIDE_W-1:0]   w_wide;
    logic [SUM_W-1:0]    w_sum;
    logic                w_over;

    // Datapath: shift out a transferred word, then append this cycle's bits
    // at the surviving fill level.
    always_comb begin
        w_vld     = 1'b0;
        w_last    = 1'b0;
        case (state_q)
            ST_RUN:   w_vld = (cnt_q >= c_OUT_W_CNT);
            ST_DRAIN: begin
                w_vld  = (cnt_q != '0);
                w_last = (cnt_q <= c_OUT_W_CNT);
            end
            default:  w_vld = 1'b0;
        endcase
        w_xfer    = w_vld && O_RDY;
        w_base    = w_xfer ? (acc_q >> OUT_W) : acc_q;
        if (!w_xfer) begin
            w_bcnt = cnt_q;
        end else if (cnt_q > c_OUT_W_CNT) begin
            w_bcnt = cnt_q - c_OUT_W_CNT;
        end else begin
            w_bcnt = '0;
        end
        w_take_in = (state_q == ST_RUN) && I_V;
        w_take_fs = (state_q == ST_RUN) && FLUSH;
        w_in_mask = 3'((4'd1 << BTR) - 4'd1);
        w_nin     = w_take_in ? BTR : 2'd0;
        w_data    = ADD_W'(w_take_in ? (o_stream & w_in_mask) : 3'd0);
        if (w_take_fs) begin
            w_data = w_data | (ADD_W'(final_state) << w_nin);
        end
        w_nadd    = NADD_W'(w_nin) + (w_take_fs ? NADD_W'(STATE_W) : NADD_W'(0));
        w_wide    = {{ADD_W{1'b0}}, w_base} | (WIDE_W'(w_data) << w_bcnt);
        w_sum     = SUM_W'(w_bcnt) + SUM_W'(w_nadd);
        w_over    = (w_sum > c_ACC_W_SUM);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = w_wide[ACC_W-1:0];
        cnt_d   = w_over ? c_ACC_W_CNT : CNT_W'(w_sum);
        bits_d  = bits_q + BITS_W'(w_nadd);
        ovf_d   = ovf_q | w_over;
        case (state_q)
            ST_RUN: begin
                if (FLUSH) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0 || (w_xfer && w_last)) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                acc_d = '0;
                cnt_d = '0;
                if (I_F) begin
                    bits_d  = '0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge PHI) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
            bits_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            ovf_q   <= ovf_d;
        end
    end

    assign O_VLD  = w_vld;
    assign O_LAST = w_last;
    assign O_WORD = acc_q[OUT_W-1:0];
    assign O_BITS = bits_q;
    assign O_DONE = (state_q == ST_DONE);
    assign O_OVF  = ovf_q;

endmodule
`default_nettype wire
